// File: rtl/router_pkg.sv
// Shared definitions for the XY-mesh switch: port numbering and arbiter FSM states.
package router_pkg;

  localparam int PORT_N = 5;
  localparam int PORT_W = $clog2(PORT_N);

  localparam logic [PORT_W-1:0] PORT_LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] PORT_NORTH = 3'd1;
  localparam logic [PORT_W-1:0] PORT_EAST  = 3'd2;
  localparam logic [PORT_W-1:0] PORT_SOUTH = 3'd3;
  localparam logic [PORT_W-1:0] PORT_WEST  = 3'd4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/xy_route_calc.sv
// Combinational dimension-ordered (X first, then Y) route computation.
// Maps a destination {dst_x, dst_y} and this router's coordinates to an output port.
module xy_route_calc
  import router_pkg::*;
#(
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int X_CORD = 0,
  parameter int Y_CORD = 0
) (
  input  logic [X_W-1:0]    dst_x,
  input  logic [Y_W-1:0]    dst_y,
  output logic [PORT_W-1:0] out_port
);

  localparam logic [X_W-1:0] X_HERE = X_W'(X_CORD);
  localparam logic [Y_W-1:0] Y_HERE = Y_W'(Y_CORD);

  // Resolve X first; only once the column matches does Y decide.
  always_comb begin
    out_port = PORT_LOCAL;
    if (dst_x > X_HERE)      out_port = PORT_EAST;
    else if (dst_x < X_HERE) out_port = PORT_WEST;
    else if (dst_y > Y_HERE) out_port = PORT_NORTH;
    else if (dst_y < Y_HERE) out_port = PORT_SOUTH;
  end

endmodule

// File: rtl/xy_route_arbiter.sv
// Route-and-arbitrate stage: round-robin pick of a valid head packet, XY route,
// selections held until the write strobe consumes the grant.
// Optional feature: define XYA_ROUTE_ERR_EN to add the sticky route-error output err_o.
module xy_route_arbiter
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MESH_X     = 3,
  parameter int MESH_Y     = 3,
  parameter int X_CORD     = 0,
  parameter int Y_CORD     = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [PORT_N-1:0]            vld_input_i,
  input  logic [PORT_N*DATA_WIDTH-1:0] data_i,
  input  logic [PORT_N-1:0]            wr_en_i,
  output logic                         grant_vld_o,
  output logic [PORT_W-1:0]            mux_in_sel_o,
  output logic [PORT_W-1:0]            mux_out_sel_o
`ifdef XYA_ROUTE_ERR_EN
  ,
  output logic                         err_o
`endif
);

  localparam int X_W = $clog2(MESH_X);
  localparam int Y_W = $clog2(MESH_Y);

  arb_state_t        state;
  logic [PORT_W-1:0] rr_ptr;
  logic [PORT_W-1:0] pick_idx;
  logic              pick_vld;
  logic [X_W-1:0]    dst_x;
  logic [Y_W-1:0]    dst_y;
  logic [PORT_W-1:0] route_port;

  // Round-robin scan starting just after the last consumed port; nearest valid wins.
  always_comb begin
    int cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = PORT_N; k >= 1; k--) begin
      cand = (int'(rr_ptr) + k) % PORT_N;
      if (vld_input_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = PORT_W'(cand);
      end
    end
  end

  // Destination fields of the candidate packet sit in its MSBs.
  always_comb begin
    dst_x = data_i[int'(pick_idx)*DATA_WIDTH + DATA_WIDTH - 1 -: X_W];
    dst_y = data_i[int'(pick_idx)*DATA_WIDTH + DATA_WIDTH - 1 - X_W -: Y_W];
  end

  xy_route_calc #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .X_CORD (X_CORD),
    .Y_CORD (Y_CORD)
  ) u_route (
    .dst_x    (dst_x),
    .dst_y    (dst_y),
    .out_port (route_port)
  );

  // Arbiter FSM: latch a selection in IDLE, hold it in GRANT until consumed or abandoned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      grant_vld_o   <= 1'b0;
      mux_in_sel_o  <= '0;
      mux_out_sel_o <= '0;
      rr_ptr        <= PORT_W'(PORT_N - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            mux_in_sel_o  <= pick_idx;
            mux_out_sel_o <= route_port;
            grant_vld_o   <= 1'b1;
            state         <= ST_GRANT;
          end else begin
            grant_vld_o <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (|wr_en_i) begin
            rr_ptr      <= mux_in_sel_o;
            grant_vld_o <= 1'b0;
            state       <= ST_IDLE;
          end else if (!vld_input_i[mux_in_sel_o]) begin
            // Packet vanished before being written: drop the grant, keep fairness pointer.
            grant_vld_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          grant_vld_o <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef XYA_ROUTE_ERR_EN
  logic route_bad;

  // Destination outside the mesh, or a route back out of the port it arrived on.
  always_comb begin
    route_bad = (int'(dst_x) >= MESH_X) || (int'(dst_y) >= MESH_Y) ||
                ((route_port == pick_idx) && (route_port != PORT_LOCAL));
  end

  // Sticky error flag, evaluated only when a new grant is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (state == ST_IDLE && pick_vld && route_bad) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_xy_route_arbiter.sv
// Scoreboard bench for xy_route_arbiter (router at (1,1) in a 3x3 mesh, 8-bit packets).
module tb_xy_route_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  vld = '0;
  logic [39:0] data = '0;
  logic [4:0]  wr_en = '0;
  logic        gv;
  logic [2:0]  in_sel;
  logic [2:0]  out_sel;
`ifdef XYA_ROUTE_ERR_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  xy_route_arbiter #(
    .DATA_WIDTH (8),
    .MESH_X     (3),
    .MESH_Y     (3),
    .X_CORD     (1),
    .Y_CORD     (1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .vld_input_i   (vld),
    .data_i        (data),
    .wr_en_i       (wr_en),
    .grant_vld_o   (gv),
    .mux_in_sel_o  (in_sel),
    .mux_out_sel_o (out_sel)
`ifdef XYA_ROUTE_ERR_EN
    ,
    .err_o         (err)
`endif
  );

  typedef struct {
    int in_p;
    int out_p;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_ptr = 4;
  bit   model_err = 1'b0;

  // Reference: ports LOCAL=0 NORTH=1 EAST=2 SOUTH=3 WEST=4; router at x=1, y=1.
  function automatic int route(int x, int y);
    if (x > 1) return 2;
    if (x < 1) return 4;
    if (y > 1) return 1;
    if (y < 1) return 3;
    return 0;
  endfunction

  function automatic int pick(logic [4:0] v);
    for (int k = 1; k <= 5; k++) begin
      if (v[(last_ptr + k) % 5]) return (last_ptr + k) % 5;
    end
    return -1;
  endfunction

  function automatic logic [39:0] rand_data();
    logic [39:0] d;
    for (int p = 0; p < 5; p++) d[p*8 +: 8] = 8'($urandom);
    return d;
  endfunction

  function automatic logic [7:0] pkt(int x, int y);
    logic [7:0] b;
    b = {2'(x), 2'(y), 4'($urandom)};
    return b;
  endfunction

  // Predict the grant the design must issue for this vld/data and queue it.
  task automatic push_exp(input logic [4:0] v, input logic [39:0] d, output int idx);
    int x;
    int y;
    int o;
    idx = pick(v);
    x = int'(d[idx*8+6 +: 2]);
    y = int'(d[idx*8+4 +: 2]);
    o = route(x, y);
    if (x >= 3 || y >= 3 || (o == idx && o != 0)) model_err = 1'b1;
    exp_q.push_back('{in_p: idx, out_p: o, err: model_err});
  endtask

  task automatic wait_grant(output bit ok);
    @(negedge clk);
    checks++;
    ok = (gv === 1'b1);
    if (!ok) begin
      errors++;
      $display("FAIL grant_latency: grant_vld=%b, required 1 one cycle after vld", gv);
    end
  endtask

  // One packet: present it, hold the grant for some cycles, then consume (rel=1) or abandon.
  task automatic do_tx(input logic [4:0] v, input logic [39:0] d, input int hold, input bit rel);
    int idx;
    bit ok;
    logic [4:0] vv;
    vld = v;
    data = d;
    wr_en = '0;
    push_exp(v, d, idx);
    wait_grant(ok);
    if (!ok) begin
      exp_q.delete();
      vld = '0;
      return;
    end
    repeat (hold) begin
      vv = 5'($urandom);
      vv[idx] = 1'b1;
      vld = vv;
      data = rand_data();
      @(negedge clk);
    end
    vv = 5'($urandom);
    vv[idx] = 1'b0;
    vld = vv;
    if (rel) begin
      wr_en = 5'($urandom_range(1, 31));
      last_ptr = idx;
    end
    @(negedge clk);
    checks++;
    if (gv !== 1'b0) begin
      errors++;
      $display("FAIL grant_drop: grant_vld=%b, required 0 after %s", gv, rel ? "write" : "abandon");
    end
    wr_en = '0;
    vld = '0;
  endtask

  // Monitor: compare each new grant with the scoreboard, then check it stays stable.
  bit   prev_gv = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gv = 1'b0;
    end else begin
      if (gv === 1'b1 && !prev_gv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: in=%0d out=%0d with nothing expected", in_sel, out_sel);
        end else begin
          cur = exp_q.pop_front();
          if (in_sel !== 3'(cur.in_p) || out_sel !== 3'(cur.out_p)) begin
            errors++;
            $display("FAIL grant_sel: got in=%0d out=%0d, required in=%0d out=%0d",
                     in_sel, out_sel, cur.in_p, cur.out_p);
          end
`ifdef XYA_ROUTE_ERR_EN
          checks++;
          if (err !== cur.err) begin
            errors++;
            $display("FAIL err_flag: got %b, required %b", err, cur.err);
          end
`endif
        end
      end else if (gv === 1'b1 && prev_gv) begin
        checks++;
        if (in_sel !== 3'(cur.in_p) || out_sel !== 3'(cur.out_p)) begin
          errors++;
          $display("FAIL grant_hold: got in=%0d out=%0d, required in=%0d out=%0d",
                   in_sel, out_sel, cur.in_p, cur.out_p);
        end
      end
      prev_gv = (gv === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] d;
    int idx;
    bit ok;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset with nothing valid.
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (gv !== 1'b0 || in_sel !== 3'd0 || out_sel !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle: gv=%b in=%0d out=%0d, required 0 0 0", gv, in_sel, out_sel);
      end
    end

    // All ports valid: grant order 0,1,2,3,4,0 with fixed routes.
    d[7:0]   = pkt(0, 1);
    d[15:8]  = pkt(1, 2);
    d[23:16] = pkt(1, 1);
    d[31:24] = pkt(2, 2);
    d[39:32] = pkt(0, 0);
    repeat (6) do_tx(5'b11111, d, 0, 1'b1);

    // Single port to the east.
    d = rand_data();
    d[23:16] = pkt(2, 1);
    do_tx(5'b00100, d, 0, 1'b1);

    // Output full: grant held 50 cycles then consumed.
    d = rand_data();
    d[31:24] = pkt(1, 2);
    do_tx(5'b01000, d, 50, 1'b1);

    // Write strobes while idle must do nothing.
    repeat (5) begin
      wr_en = 5'($urandom_range(1, 31));
      @(negedge clk);
      checks++;
      if (gv !== 1'b0) begin
        errors++;
        $display("FAIL idle_wr_en: grant_vld=%b, required 0", gv);
      end
    end
    wr_en = '0;

    // Abandon keeps the pointer: the same port wins again.
    do_tx(5'b00011, rand_data(), 2, 1'b0);
    do_tx(5'b00011, rand_data(), 0, 1'b1);

    // Out-of-mesh destination.
    d = rand_data();
    d[23:16] = pkt(3, 0);
    do_tx(5'b00100, d, 1, 1'b1);

    // Reset while a grant is held.
    d = rand_data();
    vld = 5'b10000;
    data = d;
    push_exp(5'b10000, d, idx);
    wait_grant(ok);
    if (!ok) exp_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (gv !== 1'b0 || in_sel !== 3'd0 || out_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_grant: gv=%b in=%0d out=%0d, required 0 0 0", gv, in_sel, out_sel);
    end
`ifdef XYA_ROUTE_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%b, required 0", err);
    end
`endif
    last_ptr = 4;
    model_err = 1'b0;
    vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_tx(5'b11111, rand_data(), 0, 1'b1);

    // Randomized traffic.
    repeat (200) begin
      do_tx(5'($urandom_range(1, 31)), rand_data(), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_grant: %0d expected grants never seen, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
